// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared encodings and helpers for the PWM bank: counting-mode
//                encodings, counter direction type and channel-select width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counting-mode encodings seen on the mode input
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Counter direction; edge-aligned counting only ever uses DIR_UP
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Width of a channel select, never narrower than one bit
    function automatic int pwm_sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_counter
//  Description : Shared PWM time base. Steps an up (edge) or up/down (center)
//                count against the active period and flags the boundary
//                cycle, i.e. the last cycle of each count sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_mode,
    input  logic [N-1:0] i_period,
    output logic [N-1:0] o_count,
    output logic         o_boundary
);

    localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_count;
    logic [N-1:0] w_count_nxt;
    dir_t         r_dir;
    dir_t         w_dir_nxt;
    logic         w_boundary;

    // Boundary: every cycle while stopped or with a zero period; otherwise
    // the top count (edge) or the final descent to 1 (center, or 0,1 for P=1)
    always_comb begin
        w_boundary = 1'b0;
        if (!i_en || (i_period == '0)) begin
            w_boundary = 1'b1;
        end else if (i_mode == MODE_EDGE) begin
            w_boundary = (r_count == i_period);
        end else begin
            w_boundary = (r_count == C_ONE) &&
                         ((r_dir == DIR_DOWN) || (i_period == C_ONE));
        end
    end

    // Next count and direction; a boundary always restarts at 0 counting up
    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (w_boundary) begin
            w_count_nxt = '0;
            w_dir_nxt   = DIR_UP;
        end else if (i_mode == MODE_EDGE) begin
            w_count_nxt = r_count + C_ONE;
        end else if (r_dir == DIR_UP) begin
            if (r_count == i_period) begin
                // Peak reached: turn around without repeating the top count
                w_count_nxt = r_count - C_ONE;
                w_dir_nxt   = DIR_DOWN;
            end else begin
                w_count_nxt = r_count + C_ONE;
            end
        end else begin
            w_count_nxt = r_count - C_ONE;
        end
    end

    // Count and direction state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign o_count    = r_count;
    assign o_boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_bank
//  Description : Bank of CH PWM channels sharing one time base. Levels are
//                written through a per-channel shadow register and take
//                effect only at a period boundary; mode and period are
//                likewise latched at the boundary. Outputs are registered
//                with per-channel polarity inversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int CW = pwm_sel_width(CH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic [N-1:0]  period,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [CW-1:0] wr_ch,
    input  logic [N-1:0]  wr_level,
    input  logic [CH-1:0] inv,
    output logic [CH-1:0] out,
    output logic          period_end
);

    logic          r_act_mode;
    logic [N-1:0]  r_act_period;
    logic          r_period_end;
    logic [N-1:0]  w_count;
    logic          w_boundary;
    logic [CH-1:0] w_hit;
    logic [CH-1:0] w_pending;
    logic          w_accept;
    logic          w_period_live;

    pwm_counter #(
        .N(N)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_en       (en),
        .i_mode     (r_act_mode),
        .i_period   (r_act_period),
        .o_count    (w_count),
        .o_boundary (w_boundary)
    );

    // Active mode/period only change at a boundary so a period never truncates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_mode   <= MODE_EDGE;
            r_act_period <= '0;
        end else if (w_boundary) begin
            r_act_mode   <= mode;
            r_act_period <= period;
        end
    end

    // Boundary pulse, delayed one cycle and suppressed while stopped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= w_boundary & en;
        end
    end

    // An out-of-range channel hits no bit and is therefore never ready
    assign wr_ready      = |(w_hit & ~w_pending);
    assign w_accept      = wr_valid & wr_ready;
    assign w_period_live = en & (r_act_period != '0);
    assign period_end    = r_period_end;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [N-1:0] r_shadow;
            logic [N-1:0] r_level;
            logic         r_pending;
            logic         r_out;
            logic         w_load;
            logic         w_raw;

            assign w_hit[gi]     = (wr_ch == CW'(gi));
            assign w_pending[gi] = r_pending;
            assign w_load        = w_accept & w_hit[gi];
            assign w_raw         = w_period_live & (w_count < r_level);

            // Shadow capture, boundary transfer to the active level, and the
            // registered polarity-adjusted output. A write accepted on the
            // boundary cycle stays pending: the copy uses the old shadow.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shadow  <= '0;
                    r_level   <= '0;
                    r_pending <= 1'b0;
                    r_out     <= 1'b0;
                end else begin
                    if (w_load) begin
                        r_shadow <= wr_level;
                    end
                    if (w_boundary && r_pending) begin
                        r_level <= r_shadow;
                    end
                    if (w_load) begin
                        r_pending <= 1'b1;
                    end else if (w_boundary) begin
                        r_pending <= 1'b0;
                    end
                    r_out <= w_raw ^ inv[gi];
                end
            end

            assign out[gi] = r_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_bank
//  Description : Directed self-checking bench for pwm_bank (N=8, CH=4).
//                Output waveforms are captured one bit per cycle and compared
//                against hand-derived patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;

    localparam int N  = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          mode;
    logic [N-1:0]  period;
    logic          wr_valid;
    logic          wr_ready;
    logic [CW-1:0] wr_ch;
    logic [N-1:0]  wr_level;
    logic [CH-1:0] inv;
    logic [CH-1:0] out;
    logic          period_end;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [31:0]   obs_a;
    logic [31:0]   obs_b;

    always #5 clk = ~clk;

    pwm_bank #(
        .N  (N),
        .CH (CH),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .period     (period),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_level   (wr_level),
        .inv        (inv),
        .out        (out),
        .period_end (period_end)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [CW-1:0] ch, input logic [N-1:0] lvl);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_level = lvl;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        period   = '0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_level = '0;
        inv      = 4'hF;

        // Reset state: outputs low regardless of inv, nothing pending
        tick();
        tick();
        check("reset_out", {28'd0, out}, 32'h0);
        check("reset_period_end", {31'd0, period_end}, 32'h0);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'h1);

        // Stopped: out follows inv, no period_end
        reset = 1'b0;
        tick();
        check("stopped_out_inv", {28'd0, out}, 32'hF);
        check("stopped_period_end", {31'd0, period_end}, 32'h0);
        inv = 4'h0;

        // Edge: period 9, ch0 level 3 -> high cycles 0..2 of every 10
        mode   = 1'b0;
        period = 8'd9;
        write(2'd0, 8'd3);
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        obs_b = '0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            obs_a[j-1] = out[0];
            obs_b[j-1] = period_end;
        end
        check("edge_out0", obs_a, 32'h01C07);
        check("edge_period_end", obs_b, 32'h80200);

        // Center: period 4, level 2 -> counts 0,1,2,3,4,3,2,1; high at 0,1,1
        en     = 1'b0;
        mode   = 1'b1;
        period = 8'd4;
        write(2'd0, 8'd2);
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        obs_b = '0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            obs_a[j-1] = out[0];
            obs_b[j-1] = period_end;
        end
        check("center_out0", obs_a, 32'h8383);
        check("center_period_end", obs_b, 32'h8080);

        // Shadow: ch1=5 written mid-period, applies from next period;
        // a second write before the boundary is refused
        mode   = 1'b0;
        period = 8'd9;
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        for (int j = 1; j <= 20; j++) begin
            wr_valid = 1'b0;
            if (j == 4) begin
                wr_ch    = 2'd1;
                wr_level = 8'd5;
                wr_valid = 1'b1;
                check("shadow_ready_free", {31'd0, wr_ready}, 32'h1);
            end
            if (j == 6) begin
                wr_ch    = 2'd1;
                wr_level = 8'd7;
                wr_valid = 1'b1;
                check("shadow_ready_busy", {31'd0, wr_ready}, 32'h0);
            end
            tick();
            obs_a[j-1] = out[1];
        end
        wr_valid = 1'b0;
        wr_ch    = 2'd1;
        check("shadow_out1", obs_a, 32'h07C00);
        check("shadow_ready_after_b", {31'd0, wr_ready}, 32'h1);

        // Bounds: ch2 level 0 always low, ch3 level 255 always high;
        // inversion applied from cycle 10 flips both
        en = 1'b0;
        write(2'd2, 8'd0);
        write(2'd3, 8'd255);
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        obs_b = '0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 11) inv = 4'b1100;
            tick();
            obs_a[j-1] = out[2];
            obs_b[j-1] = out[3];
        end
        check("bounds_level0", obs_a, 32'hFFC00);
        check("bounds_level255", obs_b, 32'h003FF);
        inv = 4'h0;

        // Period 9 -> 3 requested at cycle 4: old period completes first
        en     = 1'b0;
        period = 8'd9;
        write(2'd0, 8'd3);
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        obs_b = '0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 5) period = 8'd3;
            tick();
            obs_a[j-1] = out[0];
            obs_b[j-1] = period_end;
        end
        check("period_change_out0", obs_a, 32'hDDC07);
        check("period_change_pe", obs_b, 32'h22200);

        // Reset mid-period with a pending write
        period = 8'd9;
        idle(1);
        inv = 4'hF;
        en  = 1'b1;
        repeat (3) tick();
        write(2'd2, 8'd9);
        check("pre_reset_pending", {31'd0, wr_ready}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("midreset_out", {28'd0, out}, 32'h0);
        check("midreset_period_end", {31'd0, period_end}, 32'h0);
        check("midreset_wr_ready", {31'd0, wr_ready}, 32'h1);
        reset = 1'b0;
        inv   = 4'h0;
        obs_a = '0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            obs_a[3:0] = obs_a[3:0] | out;
        end
        check("post_reset_out", obs_a, 32'h0);

        // Zero period: outputs low despite a nonzero level, boundary each cycle
        period = 8'd0;
        en     = 1'b0;
        write(2'd0, 8'd5);
        idle(1);
        en    = 1'b1;
        obs_a = '0;
        obs_b = '0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            obs_a[j-1] = out[0];
            obs_b[j-1] = period_end;
        end
        check("zero_period_out0", obs_a, 32'h0);
        check("zero_period_pe", obs_b, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
